sw_debouncer: RTL and testbench

//  Synchronises and debounces the slide-switch bank, then presents a clean

---
 rtl/sw_debouncer.sv | 97 +++++++++
 tb/tb_sw_debouncer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// Switch-bank synchroniser and debouncer.
// Each switch bit passes through a two-flop synchroniser and then a small
// per-bit settle FSM. A bit only takes a new level after the synchronised input
// has disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
// sw_changed pulses for one cycle whenever any bit of sw_stable updates.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_STABLE   | sync2 matches sw_stable for this bit, counter held at 0
// ST_SETTLING | sync2 differs from sw_stable, counter counts mismatch cycles
module sw_debouncer #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle window the first mismatching cycle commits directly,
    // so the counter never leaves 0 and cannot wrap.
    localparam bit ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } bit_state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] commit;
    bit_state_t       state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];

    // Two-flop synchroniser; only sync2 is allowed to reach the debounce logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit mismatch and commit decision for the current cycle.
    always_comb begin
        mismatch = sync2 ^ sw_stable;
        commit   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mismatch[i]) begin
                if (state[i] == ST_STABLE)
                    commit[i] = ONE_CYCLE;
                else
                    commit[i] = (cnt[i] == CNT_LAST);
            end
        end
    end

    assign busy = |mismatch;

    // Per-bit settle FSMs, debounced outputs and the merged change strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_stable  <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sw_changed <= |commit;
            for (int i = 0; i < WIDTH; i++) begin
                if (commit[i]) begin
                    sw_stable[i] <= sync2[i];
                    state[i]     <= ST_STABLE;
                    cnt[i]       <= '0;
                end else if (!mismatch[i]) begin
                    state[i] <= ST_STABLE;
                    cnt[i]   <= '0;
                end else if (state[i] == ST_STABLE) begin
                    state[i] <= ST_SETTLING;
                    cnt[i]   <= CNT_W'(1);
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: a DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1
// instance share the same stimulus. A reference model counts consecutive
// mismatching samples per bit and is compared on every cycle; directed tables
// and sequences pin down the documented timing.
module tb_sw_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] sw_raw = 5'h1F;

    logic [4:0] st4, st1;
    logic       ch4, ch1, bz4, bz1;

    int total = 0;
    int bad   = 0;

    sw_debouncer #(.WIDTH(5), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_stable  (st4),
        .sw_changed (ch4),
        .busy       (bz4)
    );

    sw_debouncer #(.WIDTH(5), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_stable  (st1),
        .sw_changed (ch1),
        .busy       (bz1)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is the 4-cycle instance, index 1 the 1-cycle one.
    int         m_dc [2] = '{4, 1};
    logic [4:0] m_s1 [2];
    logic [4:0] m_s2 [2];
    logic [4:0] m_st [2];
    logic       m_ch [2];
    int         m_run [2][5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_s1[m] = '0;
            m_s2[m] = '0;
            m_st[m] = '0;
            m_ch[m] = 1'b0;
            for (int i = 0; i < 5; i++) m_run[m][i] = 0;
        end
    endtask

    // One clock edge of the model: a bit takes the synchronised level once it
    // has disagreed for m_dc consecutive samples.
    task automatic model_step();
        logic [4:0] old;
        for (int m = 0; m < 2; m++) begin
            old = m_st[m];
            for (int i = 0; i < 5; i++) begin
                if (m_s2[m][i] != old[i]) begin
                    m_run[m][i]++;
                    if (m_run[m][i] == m_dc[m]) begin
                        m_st[m][i]  = m_s2[m][i];
                        m_run[m][i] = 0;
                    end
                end else begin
                    m_run[m][i] = 0;
                end
            end
            m_ch[m] = (m_st[m] != old);
            m_s2[m] = m_s1[m];
            m_s1[m] = sw_raw;
        end
    endtask

    // Drive inputs mid-cycle, take one edge, compare both instances to the model.
    task automatic step(input logic [4:0] raw, input logic r);
        @(negedge clk);
        sw_raw = raw;
        rst    = r;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
        chk("m4_stable",  st4, m_st[0]);
        chk("m4_changed", ch4, m_ch[0]);
        chk("m4_busy",    bz4, (m_s2[0] != m_st[0]));
        chk("m1_stable",  st1, m_st[1]);
        chk("m1_changed", ch1, m_ch[1]);
        chk("m1_busy",    bz1, (m_s2[1] != m_st[1]));
    endtask

    typedef struct {
        logic [4:0] raw;
        logic [4:0] st;
        logic       ch;
        logic       bz;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int         pulses;
        int         first_a;
        int         first_b;
        int         q [$];
        logic [4:0] raw;

        tbl[0]  = '{5'h1F, 5'h00, 1'b0, 1'b0};
        tbl[1]  = '{5'h1F, 5'h00, 1'b0, 1'b1};
        tbl[2]  = '{5'h1F, 5'h00, 1'b0, 1'b1};
        tbl[3]  = '{5'h1F, 5'h00, 1'b0, 1'b1};
        tbl[4]  = '{5'h1F, 5'h00, 1'b0, 1'b1};
        tbl[5]  = '{5'h1F, 5'h1F, 1'b1, 1'b0};
        tbl[6]  = '{5'h00, 5'h1F, 1'b0, 1'b0};
        tbl[7]  = '{5'h00, 5'h1F, 1'b0, 1'b1};
        tbl[8]  = '{5'h00, 5'h1F, 1'b0, 1'b1};
        tbl[9]  = '{5'h00, 5'h1F, 1'b0, 1'b1};
        tbl[10] = '{5'h00, 5'h1F, 1'b0, 1'b1};
        tbl[11] = '{5'h00, 5'h00, 1'b1, 1'b0};
        tbl[12] = '{5'h01, 5'h00, 1'b0, 1'b0};
        tbl[13] = '{5'h01, 5'h00, 1'b0, 1'b1};
        tbl[14] = '{5'h01, 5'h00, 1'b0, 1'b1};
        tbl[15] = '{5'h01, 5'h00, 1'b0, 1'b1};
        tbl[16] = '{5'h01, 5'h00, 1'b0, 1'b1};
        tbl[17] = '{5'h01, 5'h01, 1'b1, 1'b0};
        tbl[18] = '{5'h01, 5'h01, 1'b0, 1'b0};

        // Reset with all switches high: outputs must be clear before any edge.
        model_reset();
        #2;
        chk("rst_stable",  st4, 5'h00);
        chk("rst_changed", ch4, 1'b0);
        chk("rst_busy",    bz4, 1'b0);
        step(5'h1F, 1'b0);
        step(5'h1F, 1'b0);

        // Release, settle to 1F, back to 00, then a clean rise on bit 0.
        for (int k = 0; k < 19; k++) begin
            step(tbl[k].raw, 1'b1);
            chk($sformatf("tbl%0d_stable", k),  st4, tbl[k].st);
            chk($sformatf("tbl%0d_changed", k), ch4, tbl[k].ch);
            chk($sformatf("tbl%0d_busy", k),    bz4, tbl[k].bz);
        end

        // Glitch on bit 3 lasting 3 cycles must be rejected.
        pulses = 0;
        for (int k = 0; k < 3; k++) begin step(5'h09, 1'b1); pulses += int'(ch4); end
        for (int k = 0; k < 8; k++) begin step(5'h01, 1'b1); pulses += int'(ch4); end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_stable", st4, 5'h01);
        chk("glitch_busy",   bz4, 1'b0);

        // Bounce on bit 2, then held high: commit 6 edges after the last rise.
        pulses  = 0;
        first_a = -1;
        step(5'h05, 1'b1); pulses += int'(ch4);
        step(5'h05, 1'b1); pulses += int'(ch4);
        step(5'h01, 1'b1); pulses += int'(ch4);
        step(5'h01, 1'b1); pulses += int'(ch4);
        for (int k = 0; k < 10; k++) begin
            step(5'h05, 1'b1);
            pulses += int'(ch4);
            if (first_a < 0 && st4[2]) first_a = k;
        end
        chk("bounce_commit_edge", first_a, 5);
        chk("bounce_pulses",      pulses,  1);

        // Bits 1 and 4 rising together: same commit edge, one pulse.
        pulses  = 0;
        first_a = -1;
        first_b = -1;
        for (int k = 0; k < 10; k++) begin
            step(5'h17, 1'b1);
            pulses += int'(ch4);
            if (first_a < 0 && st4[1]) first_a = k;
            if (first_b < 0 && st4[4]) first_b = k;
        end
        chk("simul_bit1_edge", first_a, 5);
        chk("simul_bit4_edge", first_b, 5);
        chk("simul_pulses",    pulses,  1);

        // Bit 4 rising two cycles after bit 1: two separate pulses.
        for (int k = 0; k < 10; k++) step(5'h05, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step((k < 2) ? 5'h07 : 5'h17, 1'b1);
            if (ch4) q.push_back(k);
        end
        chk("stagger_pulse_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("stagger_pulse0", q[0], 5);
            chk("stagger_pulse1", q[1], 7);
        end
        chk("stagger_stable", st4, 5'h17);

        // Reset in the middle of a settle on bit 0.
        for (int k = 0; k < 8; k++) step(5'h04, 1'b1);
        for (int k = 0; k < 3; k++) step(5'h05, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_stable4", st4, 5'h00);
        chk("async_rst_stable1", st1, 5'h00);
        chk("async_rst_changed", ch4, 1'b0);
        chk("async_rst_busy",    bz4, 1'b0);
        step(5'h05, 1'b0);
        step(5'h05, 1'b0);
        pulses  = 0;
        first_a = -1;
        for (int k = 0; k < 10; k++) begin
            step(5'h05, 1'b1);
            pulses += int'(ch4);
            if (first_a < 0 && st4 == 5'h05) first_a = k;
        end
        chk("rst_release_commit_edge", first_a, 5);
        chk("rst_release_pulses",      pulses,  1);

        // Random switch activity with long and short holds, one reset pulse.
        raw = 5'h05;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0)
                raw = raw ^ (5'h01 << $urandom_range(0, 4));
            step(raw, (k == 200) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
